// File: rtl/uart_tx.sv
// uart_tx: APB-driven UART transmitter. Frame is start, DATA_W bits LSB first,
// optional even parity (define UART_TX_PARITY_EN), one stop bit.
// Ports: PCLK, PRESETn (async, active low), tx_en (rising edge starts a frame),
//   tx_rst (sync soft reset), baud_div (PCLK cycles per bit, 0 acts as 1),
//   tx_data (latched at frame start), tx (idle high), tx_busy, tx_done (pulse).
module uart_tx #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 19
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              tx_en,
  input  logic              tx_rst,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  localparam logic [BAUD_W-1:0] ONE  = BAUD_W'(1);
  localparam logic [BC_W-1:0]   LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0]   BC1  = BC_W'(1);

  logic [2:0]        state;
  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] div_eff;
  logic [BC_W-1:0]   bitcnt;
  logic [DATA_W-1:0] shift;
  logic              tx_en_q;
  logic              start;
  logic              bit_tick;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign div_eff  = (baud_div == '0) ? ONE : baud_div;
  assign bit_tick = (cnt == div_eff - ONE);
  assign start    = tx_en & ~tx_en_q & (state == IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      bitcnt  <= '0;
      cnt     <= '0;
      shift   <= '0;
      tx_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_en_q <= tx_en;
      if (tx_rst) begin
        state   <= IDLE;
        tx      <= 1'b1;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
        bitcnt  <= '0;
        cnt     <= '0;
      end else begin
        tx_done <= 1'b0;
        if (state != IDLE) begin
          cnt <= bit_tick ? '0 : cnt + ONE;
        end
        unique case (state)
          IDLE: begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            if (start) begin
              shift   <= tx_data;
              state   <= START;
              tx      <= 1'b0;
              tx_busy <= 1'b1;
              cnt     <= '0;
`ifdef UART_TX_PARITY_EN
              par     <= ^tx_data;
`endif
            end
          end
          START: begin
            if (bit_tick) begin
              state  <= DATA;
              tx     <= shift[0];
              bitcnt <= '0;
            end
          end
          DATA: begin
            if (bit_tick) begin
              if (bitcnt == LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= par;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                shift  <= shift >> 1;
                tx     <= shift[1];
                bitcnt <= bitcnt + BC1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_tick) begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end
`endif
          STOP: begin
            tx <= 1'b1;
            if (bit_tick) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that consumes the control outputs of the APB slave register block (tx_en, tx_rst, baud_div, tx_data). It serialises one byte per frame onto the tx line: start bit, data bits LSB first, optional parity, one stop bit. It reports tx_busy and tx_done back to the slave's status register. It sits directly downstream of the APB slave, in the PCLK domain.

Parameters:
DATA_W, 8, data bits per frame (tx_data width)
BAUD_W, 19, width of baud_div and of the internal bit-period counter

Ports:
PCLK  input  1  system clock; all logic is on its rising edge
PRESETn  input  1  asynchronous active-low reset
tx_en  input  1  level from CTRL_REG[3]; a rising edge requests one frame
tx_rst  input  1  level from CTRL_REG[2]; synchronous active-high soft reset
baud_div  input  BAUD_W  PCLK cycles per bit period
tx_data  input  DATA_W  byte to send; sampled at frame start
tx  output  1  serial line; idle high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (PRESETn=0, async): state=IDLE, tx=1, tx_busy=0, tx_done=0, bit counter=0, baud counter=0, shift reg=0, tx_en_q=0. All outputs are registered.
- Edge detect: tx_en_q <= tx_en every cycle. start = tx_en & ~tx_en_q & (state==IDLE).
- A rising edge of tx_en outside IDLE is ignored and is not queued. tx_en held high sends exactly one frame. Another frame needs tx_en to go 0 then 1.
- tx_rst=1 (synchronous, checked every cycle) overrides everything else:
  - state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0.
  - A frame in progress is aborted, with no tx_done.
  - tx_en_q still tracks tx_en, so a tx_en edge during tx_rst is lost.
- Effective divisor: div_eff = baud_div when baud_div>=1; div_eff = 1 when baud_div=0.
  - The baud counter counts 0..div_eff-1. bit_tick = (cnt==div_eff-1), after which cnt returns to 0.
  - baud_div is sampled continuously; a change mid-frame takes effect from the next counter compare.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: tx=1, busy=0. On start: shift <= tx_data, state <= START, tx <= 0, busy <= 1, cnt <= 0.
  - START: on bit_tick: state <= DATA, tx <= shift[0], bitcnt <= 0.
  - DATA: on bit_tick:
    - if bitcnt==DATA_W-1: state <= PARITY or STOP.
    - otherwise: shift >>= 1, tx <= next bit, bitcnt++.
  - STOP: tx=1. On bit_tick: state <= IDLE, busy <= 0, tx_done <= 1 for exactly one cycle.
- Latency: tx falls on the edge after start is sampled. The frame lasts (2+DATA_W)*div_eff cycles, or (3+DATA_W)*div_eff with parity. tx_done rises on the same edge that busy falls.
- Back-to-back: a new start can be accepted the cycle after IDLE is re-entered (tx_done high) if tx_en shows a fresh rising edge.
- tx_data changes after frame start do not affect the frame in flight.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state follows DATA for one bit period and transmits even parity (XOR of the latched byte, computed at frame start). Frame = 11 bit periods.
- Undefined: no PARITY state or logic; DATA goes straight to STOP. Frame = 10 bit periods.

Test Plan:
- Reset: PRESETn=0 mid-frame -> tx=1, tx_busy=0, tx_done=0 immediately (async); no frame after release until a new tx_en edge.
- baud_div=4, tx_data=0xA5, tx_en 0->1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; single tx_done pulse; with UART_TX_PARITY_EN the parity bit is 0 (before stop) and busy lasts 44 cycles.
- tx_en held high 100 cycles, baud_div=2, tx_data=0x3C -> exactly one frame (20 cycles); tx_data changed to 0xFF at cycle 5 -> line still carries 0x3C.
- tx_rst=1 during DATA bit 3, baud_div=8 -> tx=1 and busy=0 next cycle; no tx_done pulse; a fresh tx_en edge after tx_rst=0 sends a full frame.
- baud_div=0 and baud_div=1, tx_data=0x01 -> both give 1-cycle bits: 0,1,0,0,0,0,0,0,0,1; frame 10 cycles.
- tx_en toggled 1->0->1 in the cycle tx_done pulses -> second frame starts with no dead bit period; the rising edge during the previous frame's DATA state is ignored.
